// File: rtl/res_pack_if.sv
// -----------------------------------------------------------------------------
// res_pack_if -- bus bundle between the result packer and its environment.
//
// Optional feature macro: RES_PACK_THR_EN (adds the thr threshold input).
//
// Signals:
//   start     env -> dut  single-cycle pack request
//   res_rd    dut -> env  result-memory read strobe
//   res_addr  dut -> env  result-memory pixel address (row*128+col)
//   res_di    env -> dut  result-memory data, valid one cycle after res_rd
//   pk_wr     dut -> env  packed-word write strobe
//   pk_addr   dut -> env  packed-word address
//   pk_do     dut -> env  packed word, bit 15 = lowest pixel address
//   fg_cnt    dut -> env  foreground pixel count, valid while done is high
//   done      dut -> env  one-cycle completion pulse
//   thr       env -> dut  foreground threshold (RES_PACK_THR_EN only)
//
// Handshake: res_rd is a fire-and-forget strobe; the memory must return
// res_di exactly one cycle later with no back-pressure. pk_wr is likewise
// a one-cycle strobe that the packed-word store must accept unconditionally.
// -----------------------------------------------------------------------------
interface res_pack_if;
   logic        start;
   logic        res_rd;
   logic [13:0] res_addr;
   logic [7:0]  res_di;
   logic        pk_wr;
   logic [9:0]  pk_addr;
   logic [15:0] pk_do;
   logic [14:0] fg_cnt;
   logic        done;
`ifdef RES_PACK_THR_EN
   logic [7:0]  thr;

   modport master (
      input  start, res_di, thr,
      output res_rd, res_addr, pk_wr, pk_addr, pk_do, fg_cnt, done
   );
   modport slave (
      output start, res_di, thr,
      input  res_rd, res_addr, pk_wr, pk_addr, pk_do, fg_cnt, done
   );
`else
   modport master (
      input  start, res_di,
      output res_rd, res_addr, pk_wr, pk_addr, pk_do, fg_cnt, done
   );
   modport slave (
      output start, res_di,
      input  res_rd, res_addr, pk_wr, pk_addr, pk_do, fg_cnt, done
   );
`endif
endinterface

// File: rtl/res_pack.sv
// -----------------------------------------------------------------------------
// res_pack -- reads a 128x128 byte result image and packs it into 1024
// 16-bit foreground bitmap words, counting foreground pixels on the way.
//
// Optional feature macro: RES_PACK_THR_EN. When defined, foreground means
// res_di > thr (thr captured when start is accepted); otherwise foreground
// means res_di != 0.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-high reset
//   bus          res_pack_if.master (start, memory read port, packed write
//                port, fg_cnt, done, optional thr)
//   dbg_state_o  out  current FSM state (IDLE=0, READ=1, DRAIN=2, FIN=3)
//
// Timing (cycle 1 = first cycle after the start-accepting edge):
//   cycle c in 1..16384 : res_rd=1, res_addr=c-1
//   end of cycle c+1    : pixel c-1 shifted into the pack register
//   cycle 16w+18        : pk_wr with word w
//   cycle 16387         : done (FIN)
// -----------------------------------------------------------------------------
module res_pack (
   input  logic              clk,
   input  logic              reset,
   res_pack_if.master        bus,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t      state_q;
   logic        res_rd_q;
   logic [13:0] res_addr_q;
   logic        smp_vld_q;   // res_di carries a requested pixel this cycle
   logic [15:0] shift_q;
   logic [3:0]  bit_cnt_q;
   logic [9:0]  word_q;
   logic        pk_wr_q;
   logic [9:0]  pk_addr_q;
   logic [15:0] pk_do_q;
   logic [14:0] fg_cnt_q;
   logic        done_q;
   logic        pix_fg;
   logic [15:0] shift_d;

`ifdef RES_PACK_THR_EN
   logic [7:0]  thr_q;
   assign pix_fg = (bus.res_di > thr_q);
`else
   assign pix_fg = (bus.res_di != 8'd0);
`endif

   // Newest pixel enters at bit 0, so after 16 shifts the oldest (lowest
   // address) pixel sits in bit 15.
   assign shift_d = {shift_q[14:0], pix_fg};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         res_rd_q   <= 1'b0;
         res_addr_q <= 14'd0;
         smp_vld_q  <= 1'b0;
         shift_q    <= 16'd0;
         bit_cnt_q  <= 4'd0;
         word_q     <= 10'd0;
         pk_wr_q    <= 1'b0;
         pk_addr_q  <= 10'd0;
         pk_do_q    <= 16'd0;
         fg_cnt_q   <= 15'd0;
         done_q     <= 1'b0;
`ifdef RES_PACK_THR_EN
         thr_q      <= 8'd0;
`endif
      end else begin
         pk_wr_q   <= 1'b0;
         done_q    <= 1'b0;
         // Read data lags the strobe by one cycle.
         smp_vld_q <= res_rd_q;

         if (smp_vld_q) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            fg_cnt_q  <= fg_cnt_q + {14'd0, pix_fg};
            if (bit_cnt_q == 4'd15) begin
               pk_wr_q   <= 1'b1;
               pk_addr_q <= word_q;
               pk_do_q   <= shift_d;
               word_q    <= word_q + 10'd1;
            end
         end

         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q    <= READ;
                  res_rd_q   <= 1'b1;
                  res_addr_q <= 14'd0;
                  fg_cnt_q   <= 15'd0;
                  shift_q    <= 16'd0;
                  bit_cnt_q  <= 4'd0;
                  word_q     <= 10'd0;
`ifdef RES_PACK_THR_EN
                  thr_q      <= bus.thr;
`endif
               end
            end
            READ: begin
               if (res_addr_q == 14'd16383) begin
                  state_q    <= DRAIN;
                  res_rd_q   <= 1'b0;
                  res_addr_q <= 14'd0;
               end else begin
                  res_addr_q <= res_addr_q + 14'd1;
               end
            end
            DRAIN: begin
               // The final word is on the write port this cycle.
               if (pk_wr_q && (pk_addr_q == 10'd1023)) begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
               end
            end
            FIN: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.res_rd   = res_rd_q;
   assign bus.res_addr = res_addr_q;
   assign bus.pk_wr    = pk_wr_q;
   assign bus.pk_addr  = pk_addr_q;
   assign bus.pk_do    = pk_do_q;
   assign bus.fg_cnt   = fg_cnt_q;
   assign bus.done     = done_q;
   assign dbg_state_o  = state_q;

endmodule
